// File: rtl/ap_ctrl_pkg.sv
// Shared types and defaults for the ap_ctrl_hs sequencer.
package ap_ctrl_pkg;

    // Default parameter values for the sequencer and its period counter.
    localparam int AP_PERIOD_DEF  = 10000;
    localparam int AP_TIMEOUT_DEF = 1000000;
    localparam int AP_CNT_W       = 32;

    // Width of the completed-run counter (wraps 0xFFFF -> 0).
    localparam int AP_RUN_W       = 16;

    // Sequencer states. The encoding is visible on the dbg_state port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_ERROR = 2'd3
    } ap_state_e;

    // True while a run is in flight (the core owns the handshake).
    function automatic logic ap_state_active(input ap_state_e s);
        return (s == ST_START) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/ap_period_tick.sv
// Periodic trigger source: counts 0..PERIOD-1 while enabled and flags the
// last count. Held at zero while disabled, so the first tick lands PERIOD
// cycles after enable rises.
module ap_period_tick
    import ap_ctrl_pkg::*;
#(
    parameter int PERIOD = AP_PERIOD_DEF,
    parameter int CNT_W  = AP_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    // Next count: wrap at PERIOD-1, hold at zero while disabled.
    always_comb begin
        at_last = (cnt_q == CNT_LAST);
        cnt_d   = cnt_q + CNT_ONE;
        if (!enable || at_last) begin
            cnt_d = '0;
        end
        tick = enable && at_last;
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ap_ctrl_sequencer.sv
// Drives an HLS core through the ap_ctrl_hs handshake. Runs are launched by
// a periodic tick or a software trigger when the core is idle; latency and
// completed runs are recorded, dropped triggers and hung runs are flagged.
//
// Handshake: ap_start acts as "valid" for a run request. It rises the cycle
// after an accepted trigger and is held until ap_ready is sampled high (the
// core has taken the request); it drops the following cycle. ap_done is a
// single-cycle completion strobe; it only counts while a run is in flight,
// and in START it completes the run only together with ap_ready.
module ap_ctrl_sequencer
    import ap_ctrl_pkg::*;
#(
    parameter int PERIOD  = AP_PERIOD_DEF,
    parameter int TIMEOUT = AP_TIMEOUT_DEF,
    parameter int CNT_W   = AP_CNT_W
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic                enable,
    input  logic                soft_trigger,
    input  logic                err_clr,
    output logic                ap_start,
    input  logic                ap_ready,
    input  logic                ap_done,
    input  logic                ap_idle,
    output logic                busy,
    output logic                done_pulse,
    output logic [AP_RUN_W-1:0] run_count,
    output logic [CNT_W-1:0]    last_latency,
    output logic                overrun,
    output logic                timeout_err,
    output logic [1:0]          dbg_state
);

    localparam logic [CNT_W-1:0]    LAT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]    LAT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [AP_RUN_W-1:0] RUN_ONE   = AP_RUN_W'(1);

    // FSM and latency counter.
    ap_state_e        state_q;
    ap_state_e        state_d;
    logic [CNT_W-1:0] lat_q;
    logic [CNT_W-1:0] lat_d;

    // Registered outputs.
    logic                ap_start_q;
    logic                ap_start_d;
    logic                busy_q;
    logic                busy_d;
    logic                done_pulse_q;
    logic                done_pulse_d;
    logic [AP_RUN_W-1:0] run_count_q;
    logic [AP_RUN_W-1:0] run_count_d;
    logic [CNT_W-1:0]    last_latency_q;
    logic [CNT_W-1:0]    last_latency_d;
    logic                overrun_q;
    logic                overrun_d;
    logic                timeout_err_q;
    logic                timeout_err_d;

    // Per-cycle events decoded by the FSM.
    logic tick;
    logic trigger;
    logic run_complete;
    logic trig_drop;
    logic run_timeout;

    ap_period_tick #(
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W)
    ) u_period_tick (
        .clk    (HCLK),
        .rst    (HRESET),
        .enable (enable),
        .tick   (tick)
    );

    // Next-state logic: launch, handshake progress, completion and timeout.
    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        run_complete = 1'b0;
        trig_drop    = 1'b0;
        run_timeout  = 1'b0;
        trigger      = tick | soft_trigger;

        case (state_q)
            ST_IDLE: begin
                // A spurious ap_done here is simply not looked at.
                if (trigger) begin
                    if (ap_idle) begin
                        state_d = ST_START;
                        lat_d   = LAT_ONE;
                    end else begin
                        trig_drop = 1'b1;
                    end
                end
            end

            ST_START: begin
                lat_d     = lat_q + LAT_ONE;
                trig_drop = trigger;
                if (ap_ready && ap_done) begin
                    run_complete = 1'b1;
                    state_d      = ST_IDLE;
                end else if ((lat_q == LAT_LIMIT) && !ap_done) begin
                    run_timeout = 1'b1;
                    state_d     = ST_ERROR;
                end else if (ap_ready) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                lat_d     = lat_q + LAT_ONE;
                trig_drop = trigger;
                if (ap_done) begin
                    run_complete = 1'b1;
                    state_d      = ST_IDLE;
                end else if (lat_q == LAT_LIMIT) begin
                    run_timeout = 1'b1;
                    state_d     = ST_ERROR;
                end
            end

            ST_ERROR: begin
                // Triggers are deliberately ignored until software clears.
                if (err_clr) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next values; sticky flags give a new event priority over err_clr.
    always_comb begin
        ap_start_d     = (state_d == ST_START);
        busy_d         = ap_state_active(state_d);
        done_pulse_d   = run_complete;
        run_count_d    = run_count_q;
        last_latency_d = last_latency_q;
        overrun_d      = overrun_q;
        timeout_err_d  = timeout_err_q;

        if (run_complete) begin
            run_count_d    = run_count_q + RUN_ONE;
            last_latency_d = lat_q;
        end

        if (trig_drop) begin
            overrun_d = 1'b1;
        end else if (err_clr) begin
            overrun_d = 1'b0;
        end

        if (run_timeout) begin
            timeout_err_d = 1'b1;
        end else if (err_clr) begin
            timeout_err_d = 1'b0;
        end
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q        <= ST_IDLE;
            lat_q          <= '0;
            ap_start_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_pulse_q   <= 1'b0;
            run_count_q    <= '0;
            last_latency_q <= '0;
            overrun_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            lat_q          <= lat_d;
            ap_start_q     <= ap_start_d;
            busy_q         <= busy_d;
            done_pulse_q   <= done_pulse_d;
            run_count_q    <= run_count_d;
            last_latency_q <= last_latency_d;
            overrun_q      <= overrun_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign ap_start     = ap_start_q;
    assign busy         = busy_q;
    assign done_pulse   = done_pulse_q;
    assign run_count    = run_count_q;
    assign last_latency = last_latency_q;
    assign overrun      = overrun_q;
    assign timeout_err  = timeout_err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// Bench for ap_ctrl_sequencer: core model, latency scoreboard, vector table,
// directed corner sequences and a randomized soft-trigger phase.
`timescale 1ns/1ps
module tb_ap_ctrl_sequencer;
    import ap_ctrl_pkg::*;

    localparam int PERIOD  = 8;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 32;

    logic             HCLK = 1'b0;
    logic             HRESET;
    logic             enable;
    logic             soft_trigger;
    logic             err_clr;
    logic             ap_start;
    logic             ap_ready;
    logic             ap_done;
    logic             ap_idle;
    logic             busy;
    logic             done_pulse;
    logic [15:0]      run_count;
    logic [CNT_W-1:0] last_latency;
    logic             overrun;
    logic             timeout_err;
    logic [1:0]       dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cycles = 0;

    // Scoreboard: expected latency per launched run, expected run count.
    logic [CNT_W-1:0] exp_q[$];
    logic [15:0]      exp_runs;

    // Core model knobs and state.
    int   core_rd;
    int   core_dd;
    logic core_hang;
    logic core_busy_force;
    logic core_act;
    logic core_fin;
    int   core_k;

    typedef struct {
        int               rd;
        int               dd;
        logic [CNT_W-1:0] lat;
    } vec_t;
    vec_t vecs[6];

    ap_ctrl_sequencer #(
        .PERIOD  (PERIOD),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .enable       (enable),
        .soft_trigger (soft_trigger),
        .err_clr      (err_clr),
        .ap_start     (ap_start),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .ap_idle      (ap_idle),
        .busy         (busy),
        .done_pulse   (done_pulse),
        .run_count    (run_count),
        .last_latency (last_latency),
        .overrun      (overrun),
        .timeout_err  (timeout_err),
        .dbg_state    (dbg_state)
    );

    // Clock and watchdog.
    always #5 HCLK = ~HCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic core_reset();
        core_act = 1'b0;
        core_fin = 1'b0;
        core_k   = 0;
    endtask

    // Core: ap_ready core_rd cycles after ap_start is first seen, ap_done
    // core_dd cycles after ap_ready (0 = same cycle), unless hung.
    task automatic core_eval();
        if (core_fin) begin
            core_act = 1'b0;
            core_fin = 1'b0;
        end
        if (!core_act && ap_start) begin
            core_act = 1'b1;
            core_k   = 0;
        end
        ap_ready = 1'b0;
        ap_done  = 1'b0;
        if (core_act) begin
            ap_ready = (core_k == core_rd);
            if (!core_hang && core_k == core_rd + core_dd) begin
                ap_done  = 1'b1;
                core_fin = 1'b1;
            end
            core_k++;
        end
        ap_idle = !core_act && !core_busy_force;
    endtask

    // One clock: core responds, edge, then sample and score completions.
    task automatic cycle();
        logic [CNT_W-1:0] lat_exp;
        core_eval();
        @(posedge HCLK);
        #1;
        cyc++;
        if (ap_start) start_cycles++;
        if (done_pulse) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done_pulse=1 expected 0 (cycle %0d)", cyc);
            end else begin
                lat_exp = exp_q.pop_front();
                exp_runs++;
                check("done_latency", last_latency, lat_exp);
                check("done_run_count", run_count, exp_runs);
            end
        end
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        enable = 1'b0;
        soft_trigger = 1'b0;
        err_clr = 1'b0;
        core_reset();
        repeat (3) cycle();
        HRESET = 1'b0;
        exp_q.delete();
        exp_runs = '0;
    endtask

    task automatic pulse_soft();
        soft_trigger = 1'b1;
        cycle();
        soft_trigger = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!done_pulse && n < budget) begin
            cycle();
            n++;
        end
        check(name, done_pulse, 1'b1);
    endtask

    initial begin
        int m_free;
        int m_beg;
        int rd;
        int dd;
        int snap;
        logic m_overrun;

        ap_ready = 1'b0;
        ap_done = 1'b0;
        ap_idle = 1'b1;
        core_rd = 1;
        core_dd = 3;
        core_hang = 1'b0;
        core_busy_force = 1'b0;
        exp_runs = '0;

        vecs[0] = '{rd: 0, dd: 0,  lat: 1};
        vecs[1] = '{rd: 1, dd: 3,  lat: 5};
        vecs[2] = '{rd: 0, dd: 5,  lat: 6};
        vecs[3] = '{rd: 3, dd: 0,  lat: 4};
        vecs[4] = '{rd: 2, dd: 7,  lat: 10};
        vecs[5] = '{rd: 1, dd: 14, lat: 16};

        // Reset values.
        do_reset();
        check("rst_ap_start", ap_start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done_pulse", done_pulse, 1'b0);
        check("rst_run_count", run_count, 16'h0);
        check("rst_last_latency", last_latency, '0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_state", dbg_state, ST_IDLE);

        // Periodic launches: PERIOD=8, ready 1 cycle after start, done 3 later.
        core_rd = 1;
        core_dd = 3;
        enable = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            cycle();
            check("period_ap_start", ap_start, (c >= 8) && ((c - 8) % 8 < 2));
            check("period_done_pulse", done_pulse, (c >= 13) && ((c - 13) % 8 == 0));
            if (c >= 8 && (c - 8) % 8 == 0) exp_q.push_back(5);
        end
        enable = 1'b0;
        repeat (8) cycle();
        check("period_runs", run_count, 16'd5);
        check("period_overrun", overrun, 1'b0);

        // Vector table of core timings via soft_trigger.
        for (int i = 0; i < 6; i++) begin
            core_rd = vecs[i].rd;
            core_dd = vecs[i].dd;
            exp_q.push_back(vecs[i].lat);
            pulse_soft();
            check("vec_start", ap_start, 1'b1);
            check("vec_busy", busy, 1'b1);
            wait_done("vec_done_seen", 40);
            check("vec_busy_at_done", busy, 1'b0);
            check("vec_timeout_err", timeout_err, 1'b0);
            cycle();
            check("vec_done_one_cycle", done_pulse, 1'b0);
        end

        // Trigger during RUN is dropped.
        core_rd = 1;
        core_dd = 6;
        exp_q.push_back(8);
        snap = start_cycles;
        pulse_soft();
        repeat (2) cycle();
        check("ovr_in_run_state", dbg_state, ST_RUN);
        pulse_soft();
        check("ovr_run_flag", overrun, 1'b1);
        wait_done("ovr_run_done", 20);
        check("ovr_no_extra_start", start_cycles - snap, 2);
        pulse_clr();
        check("ovr_clear", overrun, 1'b0);

        // Trigger with ap_idle=0 is dropped; set beats a simultaneous clear.
        core_busy_force = 1'b1;
        pulse_soft();
        check("ovr_idle0_flag", overrun, 1'b1);
        check("ovr_idle0_start", ap_start, 1'b0);
        check("ovr_idle0_busy", busy, 1'b0);
        err_clr = 1'b1;
        soft_trigger = 1'b1;
        cycle();
        err_clr = 1'b0;
        soft_trigger = 1'b0;
        check("ovr_set_wins", overrun, 1'b1);
        pulse_clr();
        check("ovr_clear2", overrun, 1'b0);
        core_busy_force = 1'b0;

        // Timeout with a hung core.
        core_rd = 1;
        core_hang = 1'b1;
        pulse_soft();
        check("to_start", ap_start, 1'b1);
        repeat (15) cycle();
        check("to_not_yet", timeout_err, 1'b0);
        check("to_busy_before", busy, 1'b1);
        cycle();
        check("to_flag", timeout_err, 1'b1);
        check("to_state", dbg_state, ST_ERROR);
        check("to_ap_start", ap_start, 1'b0);
        check("to_busy", busy, 1'b0);
        snap = start_cycles;
        pulse_soft();
        cycle();
        check("err_trig_ignored", start_cycles - snap, 0);
        check("err_no_overrun", overrun, 1'b0);
        check("err_still_error", dbg_state, ST_ERROR);
        pulse_clr();
        check("err_clr_flag", timeout_err, 1'b0);
        check("err_clr_state", dbg_state, ST_IDLE);
        core_reset();
        core_hang = 1'b0;
        core_dd = 2;
        exp_q.push_back(4);
        pulse_soft();
        check("err_relaunch", ap_start, 1'b1);
        wait_done("err_relaunch_done", 20);

        // Randomized soft triggers against a launch/occupancy model.
        repeat (2) cycle();
        m_free = cyc;
        m_beg = cyc;
        m_overrun = 1'b0;
        for (int i = 0; i < 400; i++) begin
            soft_trigger = ($urandom_range(0, 2) == 0);
            if (soft_trigger) begin
                if (cyc >= m_free) begin
                    rd = $urandom_range(0, 3);
                    dd = $urandom_range(0, 3);
                    core_rd = rd;
                    core_dd = dd;
                    exp_q.push_back(CNT_W'(rd + dd + 1));
                    m_beg = cyc + 1;
                    m_free = cyc + rd + dd + 2;
                end else begin
                    m_overrun = 1'b1;
                end
            end
            cycle();
            soft_trigger = 1'b0;
            check("rand_busy", busy, (cyc >= m_beg) && (cyc < m_free));
        end
        repeat (10) cycle();
        check("rand_all_done", exp_q.size(), 0);
        check("rand_overrun", overrun, m_overrun);

        // Reset mid-run; the later ap_done must not count.
        core_reset();
        core_rd = 1;
        core_dd = 8;
        pulse_soft();
        repeat (3) cycle();
        HRESET = 1'b1;
        cycle();
        check("mrst_ap_start", ap_start, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_done_pulse", done_pulse, 1'b0);
        check("mrst_run_count", run_count, 16'h0);
        check("mrst_last_latency", last_latency, '0);
        check("mrst_overrun", overrun, 1'b0);
        check("mrst_timeout_err", timeout_err, 1'b0);
        HRESET = 1'b0;
        exp_q.delete();
        exp_runs = '0;
        repeat (12) cycle();
        check("mrst_count_stays", run_count, 16'h0);

        // Run counter wrap from a preloaded count.
        core_reset();
        force dut.run_count_q = 16'hFFFE;
        cycle();
        release dut.run_count_q;
        cycle();
        exp_runs = 16'hFFFE;
        check("wrap_preload", run_count, 16'hFFFE);
        core_rd = 0;
        core_dd = 0;
        exp_q.push_back(1);
        pulse_soft();
        wait_done("wrap_done1", 10);
        check("wrap_ffff", run_count, 16'hFFFF);
        exp_q.push_back(1);
        pulse_soft();
        wait_done("wrap_done2", 10);
        check("wrap_zero", run_count, 16'h0000);
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ap_ctrl_sequencer.md
# ap_ctrl_sequencer

Sequences the HLS parking-spot-finder core through its ap_ctrl_hs handshake, replacing a free-running start pulse with a checked start/ready/done protocol. Launches runs from a programmable periodic tick or a software trigger, only when the core reports idle. Measures per-run latency, counts completed runs, and flags dropped triggers and hung runs. Sits between the system wrapper's control logic and the accelerator's ap_* ports.

## Interface
Parameters:
- PERIOD, 10000: cycles between periodic triggers; legal range ≥ 2.
- TIMEOUT, 1000000: maximum run length in cycles; legal range 2 ≤ TIMEOUT < 2^CNT_W.
- CNT_W, 32: width of the period and latency counters.

Ports:
- HCLK  in  1  the only clock, rising edge.
- HRESET  in  1  synchronous, active-high reset.
- enable  in  1  gates periodic triggers.
- soft_trigger  in  1  one-shot run request; honoured whether or not enable is high.
- err_clr  in  1  clears ERROR state and sticky flags.
- ap_start  out  1  to core.
- ap_ready  in  1  from core.
- ap_done  in  1  from core.
- ap_idle  in  1  from core.
- busy  out  1  high in START or RUN.
- done_pulse  out  1  one-cycle pulse per completed run.
- run_count  out  16  completed runs; wraps 0xFFFF→0.
- last_latency  out  CNT_W  cycles of the last completed run.
- overrun  out  1  sticky; a trigger was dropped.
- timeout_err  out  1  sticky; a run exceeded TIMEOUT.

## Operation
- Period counter:
  - While enable is high, counts 0..PERIOD-1 and raises an internal tick when at PERIOD-1, then returns to 0.
  - While enable is low, the counter is held at 0. The first tick therefore occurs PERIOD cycles after enable rises.
- trigger = tick | soft_trigger.
- States: IDLE, START, RUN, ERROR.
- IDLE:
  - trigger with ap_idle=1 → START.
  - trigger with ap_idle=0 → stay in IDLE, set overrun.
- START:
  - ap_start=1; the latency counter is loaded with 1 on entry.
  - ap_ready=1 with ap_done=0 → RUN.
  - ap_ready=1 with ap_done=1 → IDLE as a completed run.
- RUN:
  - ap_start=0.
  - ap_done=1 → IDLE as a completed run.
- Completed run: last_latency is set to the latency counter value in the ap_done cycle, run_count is incremented, and done_pulse is asserted.
- Latency counter increments every cycle in START and RUN.
- Timeout: if the counter equals TIMEOUT and ap_done=0 in START or RUN → ERROR, set timeout_err, drop ap_start.
- ERROR:
  - ap_start=0.
  - Triggers are ignored here and do not set overrun.
  - err_clr → IDLE.
- Trigger while in START or RUN: dropped, sets overrun.
- err_clr:
  - Clears overrun and timeout_err in any state.
  - If err_clr and a new overrun event occur in the same cycle, the set wins.
- ap_done while in IDLE (spurious) is ignored.

## Timing
- All outputs are registered.
- Reset values: ap_start=0, busy=0, done_pulse=0, run_count=0, last_latency=0, overrun=0, timeout_err=0. State=IDLE and the period counter=0.
- Trigger sampled high in cycle t → ap_start and busy high from cycle t+1.
- ap_ready sampled high in cycle t → ap_start low from cycle t+1.
- ap_done sampled high in cycle t → done_pulse high in cycle t+1 only. In the same cycle t+1, busy=0 and the last_latency and run_count updates are visible.
- A run whose ap_ready and ap_done arrive in its first START cycle reports last_latency=1.
- Back-to-back: a trigger in the cycle of done_pulse is accepted because the state is already IDLE.
- Timeout: when the counter equals TIMEOUT with no ap_done, timeout_err and the ERROR state are visible the next cycle. An ap_done in that same cycle wins and the run completes normally.
- Reset mid-run: ap_start and busy are low at the next edge; the core is expected to be reset alongside.

## Structure
- Package ap_ctrl_pkg holds:
  - the state enum (IDLE/START/RUN/ERROR);
  - default constants AP_PERIOD_DEF=10000, AP_TIMEOUT_DEF=1000000, AP_CNT_W=32;
  - run_count width AP_RUN_W=16.
- One sub-module, ap_period_tick: period counter with enable, parameterised by PERIOD and CNT_W, output tick.

## Test plan
- Reset, then PERIOD=8 with enable held high, and a core model with ap_ready one cycle after ap_start and ap_done 3 cycles later:
  - first tick at cycle 8 after enable rises;
  - ap_start held exactly until ap_ready;
  - last_latency=5 and run_count increments each period.
- soft_trigger with enable=0 and the core returning ap_ready and ap_done in the same first cycle → last_latency=1, one done_pulse, busy low the cycle after ap_done.
- Trigger during RUN and trigger with ap_idle=0 → both dropped, overrun=1, no extra ap_start. err_clr → overrun=0.
- TIMEOUT=16 with the core never raising ap_done:
  - timeout_err=1 and ERROR entered after the counter reaches 16, ap_start=0;
  - triggers are ignored;
  - err_clr returns to IDLE and the next trigger launches a run.
- HRESET asserted mid-RUN → all outputs at reset values the next cycle; run_count stays 0 even if ap_done follows.
- Force 65535 completed runs then one more → run_count wraps to 0.
